// File: rtl/shift595_pkg.sv
// Shared state encoding and sizing helpers for the daisy-chained 74HC595 driver.
package shift595_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Phase timer width; CLK_DIV and LATCH_CYCLES must fit below 2**PHASE_CNT_W.
    localparam int unsigned PHASE_CNT_W = 16;

    function automatic int unsigned frame_bits(input int unsigned num_ics);
        return num_ics * 8;
    endfunction

    function automatic int unsigned bit_cnt_width(input int unsigned num_ics);
        return $clog2(frame_bits(num_ics) + 1);
    endfunction

endpackage

// File: rtl/shift595_phase_timer.sv
// Down-counter timing one SCLK half-period or the latch pulse; reloaded on every state entry.
module shift595_phase_timer
    import shift595_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [PHASE_CNT_W-1:0] i_load_value,
    output logic                   o_phase_done
);

    logic [PHASE_CNT_W-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - PHASE_CNT_W'(1);
        end
    end

    assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/shift_register_595_chain.sv
// Serialises one frame per lane onto daisy-chained 74HC595s sharing SCLK and latch,
// with a one-deep pending slot so a new frame can be queued during a transfer.
module shift_register_595_chain
    import shift595_pkg::*;
#(
    parameter int unsigned NUM_ICS      = 2,
    parameter int unsigned NUM_LANES    = 1,
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned LSB_FIRST    = 0,
    parameter int unsigned LATCH_CYCLES = 1
)(
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   trigger_i,
    input  logic [NUM_LANES*frame_bits(NUM_ICS)-1:0] data_i,
    output logic                                   ready_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   sclk_o,
    output logic [NUM_LANES-1:0]                   data_o,
    output logic                                   latch_o
);

    localparam int unsigned N         = frame_bits(NUM_ICS);
    localparam int unsigned W         = NUM_LANES * N;
    localparam int unsigned BIT_CNT_W = bit_cnt_width(NUM_ICS);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_pend_valid;
    logic [W-1:0]           r_pending;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_sclk;
    logic                   r_latch;
    logic                   r_done;

    logic                   w_phase_done;
    logic                   w_timer_load;
    logic [PHASE_CNT_W-1:0] w_timer_value;
    logic                   w_accept;
    logic                   w_frame_boundary;
    logic                   w_start_pend;
    logic                   w_start_new;
    logic                   w_frame_start;
    logic                   w_to_pending;
    logic                   w_bit_advance;
    logic [W-1:0]           w_frame_src;

    // A new frame may begin from IDLE or at the last cycle of LATCH; the pending slot wins.
    assign w_accept         = trigger_i && !r_pend_valid;
    assign w_frame_boundary = (r_state == IDLE) || ((r_state == LATCH) && w_phase_done);
    assign w_start_pend     = w_frame_boundary && r_pend_valid;
    assign w_start_new      = w_frame_boundary && w_accept;
    assign w_frame_start    = w_start_pend || w_start_new;
    assign w_to_pending     = w_accept && !w_frame_boundary;
    assign w_frame_src      = w_start_pend ? r_pending : data_i;
    assign w_bit_advance    = (r_state == SHIFT_HI) && (w_state_next == SHIFT_LO);

    // NOTE: next-state is assigned a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_frame_start) w_state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (w_phase_done) w_state_next = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (w_phase_done) begin
                    w_state_next = (r_bit_cnt > BIT_CNT_W'(1)) ? SHIFT_LO : LATCH;
                end
            end
            LATCH: begin
                if (w_phase_done) w_state_next = w_frame_start ? SHIFT_LO : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_timer_load  = (w_state_next != r_state);
    assign w_timer_value = (w_state_next == LATCH) ? PHASE_CNT_W'(LATCH_CYCLES - 1)
                                                   : PHASE_CNT_W'(CLK_DIV - 1);

    shift595_phase_timer u_phase_timer (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .o_phase_done (w_phase_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sclk  <= (w_state_next == SHIFT_HI);
            r_latch <= (w_state_next == LATCH);
            r_done  <= (r_state == LATCH) && w_phase_done;
            if (w_frame_start) begin
                r_bit_cnt <= BIT_CNT_W'(N);
            end else if ((r_state == SHIFT_HI) && w_phase_done) begin
                r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
            end
        end
    end

    // NOTE: the data buffers are reset too; they are small flop arrays, not RAM, and a known
    // value keeps data_o deterministic after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_valid <= 1'b0;
            r_pending    <= '0;
        end else if (w_to_pending) begin
            r_pend_valid <= 1'b1;
            r_pending    <= data_i;
        end else if (w_start_pend) begin
            r_pend_valid <= 1'b0;
        end
    end

    function automatic logic head_bit(input logic [N-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[N-1];
    endfunction

    function automatic logic [N-1:0] drop_head(input logic [N-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    // The first bit goes straight to data_o on the start edge; the buffer keeps the remainder.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [N-1:0] w_src_lane;
        logic [N-1:0] r_buf;
        logic         r_bit;

        assign w_src_lane = w_frame_src[l*N +: N];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_buf <= '0;
                r_bit <= 1'b0;
            end else if (w_frame_start) begin
                r_bit <= head_bit(w_src_lane);
                r_buf <= drop_head(w_src_lane);
            end else if (w_bit_advance) begin
                r_bit <= head_bit(r_buf);
                r_buf <= drop_head(r_buf);
            end
        end

        assign data_o[l] = r_bit;
    end

    assign ready_o = !r_pend_valid;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = r_done;
    assign sclk_o  = r_sclk;
    assign latch_o = r_latch;

endmodule

// File: tb/tb_shift_register_595_chain.sv
// Directed bench for shift_register_595_chain: three configurations, table-driven frames
// plus hand-written queueing and mid-frame reset sequences.
module tb_shift_register_595_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig0, trig1, trig2;
    logic [15:0] din0, din1;
    logic [47:0] din2;
    logic        ready0, busy0, done0, sclk0, dout0, latch0;
    logic        ready1, busy1, done1, sclk1, dout1, latch1;
    logic        ready2, busy2, done2, sclk2, latch2;
    logic [2:0]  dout2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_register_595_chain u_dut0 (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig0), .data_i(din0),
        .ready_o(ready0), .busy_o(busy0), .done_o(done0),
        .sclk_o(sclk0), .data_o(dout0), .latch_o(latch0)
    );

    shift_register_595_chain #(.CLK_DIV(3), .LATCH_CYCLES(4), .LSB_FIRST(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig1), .data_i(din1),
        .ready_o(ready1), .busy_o(busy1), .done_o(done1),
        .sclk_o(sclk1), .data_o(dout1), .latch_o(latch1)
    );

    shift_register_595_chain #(.NUM_LANES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig2), .data_i(din2),
        .ready_o(ready2), .busy_o(busy2), .done_o(done2),
        .sclk_o(sclk2), .data_o(dout2), .latch_o(latch2)
    );

    typedef struct packed {
        logic       sclk;
        logic       latch;
        logic       done;
        logic       ready;
        logic       busy;
        logic [2:0] dat;
    } obs_t;

    // exp holds the transmitted stream per lane, first bit sent in bit 15 of each 16-bit field.
    typedef struct {
        string       name;
        int          dut;
        logic [47:0] data;
        logic [47:0] exp;
        int          div;
        int          lat;
        int          done_lat;
        bit          scramble;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input int idx);
        obs_t o;
        case (idx)
            0:       o = '{sclk: sclk0, latch: latch0, done: done0, ready: ready0, busy: busy0, dat: {2'b00, dout0}};
            1:       o = '{sclk: sclk1, latch: latch1, done: done1, ready: ready1, busy: busy1, dat: {2'b00, dout1}};
            default: o = '{sclk: sclk2, latch: latch2, done: done2, ready: ready2, busy: busy2, dat: dout2};
        endcase
        return o;
    endfunction

    task automatic drive(input int idx, input logic trig, input logic [47:0] d);
        case (idx)
            0:       begin trig0 = trig; din0 = d[15:0]; end
            1:       begin trig1 = trig; din1 = d[15:0]; end
            default: begin trig2 = trig; din2 = d;       end
        endcase
    endtask

    // Edge 1 is the accept edge; done_lat counts edges up to and including the one after which done_o is seen.
    task automatic run_frame(input vec_t v);
        obs_t             o, p;
        int               edges, rises, lat_w, done_at, run_len, run_min, run_max;
        logic [2:0][15:0] st;
        logic [2:0]       hi_dat;
        logic [47:0]      rnd;
        bit               hold_ok;
        @(negedge clk);
        o = observe(v.dut);
        check({v.name, " idle before"}, {o.busy, o.ready}, 2'b01);
        drive(v.dut, 1'b1, v.data);
        p = o;
        edges = 0; rises = 0; lat_w = 0; done_at = -1; run_len = 0;
        run_min = 1 << 20; run_max = 0; st = '0; hi_dat = '0; hold_ok = 1'b1;
        while (edges < 1000 && done_at < 0) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            rnd = {16'($urandom()), 32'($urandom())};
            if (edges == 1) drive(v.dut, 1'b0, v.scramble ? rnd : v.data);
            else if (v.scramble) drive(v.dut, 1'b0, rnd);
            o = observe(v.dut);
            if (o.sclk && !p.sclk) begin
                rises++;
                for (int l = 0; l < 3; l++) st[l] = {st[l][14:0], o.dat[l]};
                hi_dat = o.dat;
            end
            if (o.sclk && p.sclk && o.dat != hi_dat) hold_ok = 1'b0;
            if (edges > 1 && o.sclk != p.sclk) begin
                if (run_len < run_min) run_min = run_len;
                if (run_len > run_max) run_max = run_len;
                run_len = 1;
            end else begin
                run_len++;
            end
            if (o.latch) lat_w++;
            if (o.done) done_at = edges;
            p = o;
        end
        check({v.name, " stream"}, st, v.exp);
        check({v.name, " sclk rises"}, rises, 16);
        check({v.name, " half-period min"}, run_min, v.div);
        check({v.name, " half-period max"}, run_max, v.div);
        check({v.name, " latch width"}, lat_w, v.lat);
        check({v.name, " done latency"}, done_at, v.done_lat);
        check({v.name, " data held while sclk high"}, hold_ok, 1'b1);
        @(negedge clk);
        o = observe(v.dut);
        check({v.name, " done one cycle"}, o.done, 1'b0);
        check({v.name, " idle after"}, {o.busy, o.ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o, p;
        int          edges, rises, dones, first_done, second_done, ready_rise, lat_pulses;
        logic [31:0] stream32;

        vecs[0] = '{"a5c3",        0, 48'hA5C3, {32'h0, 16'b1010_0101_1100_0011}, 1, 1, 34, 1'b0};
        vecs[1] = '{"zeros",       0, 48'h0000, {32'h0, 16'b0000_0000_0000_0000}, 1, 1, 34, 1'b0};
        vecs[2] = '{"ones",        0, 48'hFFFF, {32'h0, 16'b1111_1111_1111_1111}, 1, 1, 34, 1'b0};
        vecs[3] = '{"isolation",   0, 48'h5AA5, {32'h0, 16'b0101_1010_1010_0101}, 1, 1, 34, 1'b1};
        vecs[4] = '{"lsb 0001",    1, 48'h0001, {32'h0, 16'b1000_0000_0000_0000}, 3, 4, 101, 1'b0};
        vecs[5] = '{"lsb 8000",    1, 48'h8000, {32'h0, 16'b0000_0000_0000_0001}, 3, 4, 101, 1'b0};
        vecs[6] = '{"lsb 1234",    1, 48'h1234, {32'h0, 16'b0010_1100_0100_1000}, 3, 4, 101, 1'b0};
        vecs[7] = '{"three lanes", 2, {16'hFFFF, 16'h0000, 16'h1234},
                    {16'hFFFF, 16'h0000, 16'b0001_0010_0011_0100}, 1, 1, 34, 1'b0};
        vecs[8] = '{"post-reset",  0, 48'h3C5A, {32'h0, 16'b0011_1100_0101_1010}, 1, 1, 34, 1'b0};

        rst = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = observe(0);
        check("reset dut0 outputs", o, 8'b0001_0000);
        o = observe(2);
        check("reset dut2 outputs", o, 8'b0001_0000);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Queueing: 1111 shifting, 2222 queued, 3333 offered while the slot is full.
        @(negedge clk);
        drive(0, 1'b1, 48'h1111);
        p = observe(0);
        edges = 0; rises = 0; dones = 0; first_done = -1; second_done = -1;
        ready_rise = -1; lat_pulses = 0; stream32 = '0;
        while (edges < 120) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            o = observe(0);
            case (edges)
                1:  drive(0, 1'b0, 48'h1111);
                5:  begin check("queue ready before second", o.ready, 1'b1); drive(0, 1'b1, 48'h2222); end
                6:  begin check("queue ready drops", o.ready, 1'b0); drive(0, 1'b0, 48'h2222); end
                8:  drive(0, 1'b1, 48'h3333);
                10: begin check("queue ready low during drop", o.ready, 1'b0); drive(0, 1'b0, 48'h3333); end
                default: ;
            endcase
            if (o.sclk && !p.sclk) begin
                rises++;
                stream32 = {stream32[30:0], o.dat[0]};
            end
            if (o.done) begin
                dones++;
                if (first_done < 0) first_done = edges;
                else if (second_done < 0) second_done = edges;
            end
            if (edges > 6 && o.ready && !p.ready && ready_rise < 0) ready_rise = edges;
            if (o.latch && !p.latch) lat_pulses++;
            p = o;
        end
        check("queue bits sent", rises, 32);
        check("queue stream", stream32, {16'h1111, 16'h2222});
        check("queue done pulses", dones, 2);
        check("queue first done", first_done, 34);
        check("queue ready rises at second start", ready_rise, first_done);
        check("queue second frame length", second_done - first_done, 33);
        check("queue latch pulses", lat_pulses, 2);
        check("queue idle at end", o.busy, 1'b0);

        // Reset after the seventh rising SCLK edge of a frame.
        @(negedge clk);
        drive(0, 1'b1, 48'hFFFF);
        p = observe(0);
        edges = 0; rises = 0;
        while (edges < 100 && rises < 7) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            drive(0, 1'b0, 48'hFFFF);
            o = observe(0);
            if (o.sclk && !p.sclk) rises++;
            p = o;
        end
        check("reset test reached bit 7", rises, 7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o = observe(0);
        check("mid-frame reset sclk", o.sclk, 1'b0);
        check("mid-frame reset latch", o.latch, 1'b0);
        check("mid-frame reset ready", o.ready, 1'b1);
        check("mid-frame reset busy/done/data", {o.busy, o.done, o.dat}, 5'b0);
        rst = 1'b0;
        dones = 0; lat_pulses = 0;
        repeat (40) begin
            @(negedge clk);
            o = observe(0);
            if (o.done) dones++;
            if (o.latch) lat_pulses++;
        end
        check("no done after abort", dones, 0);
        check("no latch after abort", lat_pulses, 0);

        run_frame(vecs[8]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
